// File: rtl/seq_div_16x8.sv
// Sequential restoring divider: NW-bit dividend / DW-bit divisor, one quotient bit per
// clock, MSB first. Valid/ready handshake on both sides, one operation in flight.
module seq_div_16x8 #(
  parameter int unsigned NW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [NW-1:0] quotient_o,
  output logic [DW-1:0] remainder_o,
  output logic          div_zero_o
);

  localparam int unsigned CntW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  // Dividend register doubles as quotient register: quotient bits shift in at the LSB.
  logic [NW-1:0]   dvd_q;
  logic [DW-1:0]   dsr_q;
  // One extra bit so the shifted partial remainder never overflows before the compare.
  logic [DW:0]     pr_q;
  logic [CntW-1:0] cnt_q;
  logic            out_valid_q;
  logic [NW-1:0]   quotient_q;
  logic [DW-1:0]   remainder_q;
  logic            div_zero_q;

  logic [DW:0]     pr_shift;
  logic [DW:0]     pr_sub;
  logic            q_bit;
  logic [DW:0]     pr_d;
  logic [NW-1:0]   dvd_d;

  // One restoring iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    pr_shift = {pr_q[DW-1:0], dvd_q[NW-1]};
    pr_sub   = pr_shift - {1'b0, dsr_q};
    q_bit    = (pr_shift >= {1'b0, dsr_q});
    pr_d     = q_bit ? pr_sub : pr_shift;
    dvd_d    = {dvd_q[NW-2:0], q_bit};
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dsr_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            dvd_q <= dividend_i;
            dsr_q <= divisor_i;
            pr_q  <= '0;
            cnt_q <= CntW'(NW - 1);
            state_q <= (divisor_i == '0) ? StDone : StCalc;
          end
        end
        StCalc: begin
          pr_q  <= pr_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            quotient_q  <= dvd_d;
            remainder_q <= pr_d[DW-1:0];
            div_zero_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (!out_valid_q) begin
            // Entered straight from idle on a zero divisor: publish one edge later.
            out_valid_q <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= dvd_q[DW-1:0];
            div_zero_q  <= 1'b1;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_div_16x8.sv
// Directed and randomised checks of the 16/8 sequential divider.
module tb_seq_div_16x8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_cnt       = 0;
  int taken        = 0;

  seq_div_16x8 #(.NW(16), .DW(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (div_zero)
  );

  always #5 clk = ~clk;

  // Count output handshakes seen by the consumer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operand pair, wait for accept, then count edges until out_valid.
  task automatic send(input logic [15:0] a, input logic [7:0] b, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;  // changes after accept must not matter
    divisor  = ~b;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Complete the output handshake and confirm out_valid drops.
  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    taken++;
    check("ov_after_take", 32'(out_valid), 32'd0);
    check("rdy_after_take", 32'(in_ready), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] q, input logic [7:0] r,
                           input logic dz, input int lat, input int exp_lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, 32'(quotient), 32'(q));
    check({tag, "_r"}, 32'(remainder), 32'(r));
    check({tag, "_dz"}, 32'(div_zero), 32'(dz));
  endtask

  initial begin
    int lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 32'(in_ready), 32'd1);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_ov", 32'(out_valid), 32'd0);
    check("idle_ready_hs", 32'(hs_cnt), 32'd0);
    out_ready = 1'b0;

    send(16'h04D2, 8'h07, lat);
    check_res("t1", 16'h00B0, 8'h02, 1'b0, lat, 16);
    take();

    send(16'hFFFF, 8'hFF, lat);
    check_res("t2a", 16'h0101, 8'h00, 1'b0, lat, 16);
    take();
    send(16'hFFFF, 8'h01, lat);
    check_res("t2b", 16'hFFFF, 8'h00, 1'b0, lat, 16);
    take();
    send(16'h0000, 8'h33, lat);
    check_res("zero_dvd", 16'h0000, 8'h00, 1'b0, lat, 16);
    take();

    send(16'h0005, 8'h0A, lat);
    check_res("t4", 16'h0000, 8'h05, 1'b0, lat, 16);
    // Stall the consumer; a new request meanwhile must be ignored.
    dividend = 16'h7777;
    divisor  = 8'h03;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_ov", 32'(out_valid), 32'd1);
      check("t4_hold_rdy", 32'(in_ready), 32'd0);
      check("t4_hold_q", 32'(quotient), 32'd0);
      check("t4_hold_r", 32'(remainder), 32'h05);
    end
    in_valid = 1'b0;
    take();

    send(16'h1234, 8'h00, lat);
    check_res("t3", 16'hFFFF, 8'h34, 1'b1, lat, 1);
    take();

    // Reset in the middle of a calculation.
    @(negedge clk);
    dividend = 16'hABCD;
    divisor  = 8'h13;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ov", 32'(out_valid), 32'd0);
    check("t5_q", 32'(quotient), 32'd0);
    check("t5_r", 32'(remainder), 32'd0);
    check("t5_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_rdy", 32'(in_ready), 32'd1);
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) stale++;
      end
      check("t5_stale", 32'(stale), 32'd0);
    end
    send(16'h00C8, 8'h0A, lat);
    check_res("t5_next", 16'h0014, 8'h00, 1'b0, lat, 16);
    take();

    // Random operands with a bounded consumer stall.
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      if (n % 97 == 0) b = 8'h00;
      if (b == 0) begin
        eq = 16'hFFFF;
        er = a[7:0];
      end else begin
        eq = a / {8'h00, b};
        er = 8'(a % {8'h00, b});
      end
      send(a, b, lat);
      check_res("rnd", eq, er, (b == 0), lat, (b == 0) ? 1 : 16);
      if (b != 0) check("rnd_rem_lt", 32'(remainder < b), 32'd1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        check("rnd_hold_q", 32'(quotient), 32'(eq));
      end
      take();
    end

    repeat (3) @(posedge clk);
    #1;
    check("hs_once", 32'(hs_cnt), 32'(taken));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
